apb_arbiter_master: RTL
=======================

APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
REQ-001 Parameter ADDR_W, default 4: APB address width.
REQ-002 Parameter DATA_W, default 32: APB data width.
REQ-003 Parameter TIMEOUT, default 16: maximum ACCESS cycles without pready before abort; legal range 2..255.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 pclk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  2  per-requester transfer request; held until that requester's done.
REQ-008 req_write  input  2  per-requester direction; 1 = write.
REQ-009 req_addr  input  2*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  input  2*DATA_W  per-requester write data, packed the same way.
REQ-011 done  output  2  one-cycle completion pulse for the granted requester.
REQ-012 err  output  1  timeout flag, valid only with done.
REQ-013 rdata  output  DATA_W  read result, valid with done.
REQ-014 psel, penable, pwrite  output  1 each  APB control.
REQ-015 paddr  output  ADDR_W  APB address.
REQ-016 pwdata  output  DATA_W  APB write data.
REQ-017 pready  input  1  slave ready.
REQ-018 prdata  input  DATA_W  slave read data.

Function
REQ-019 FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-020 IDLE: eligible = req & ~done; if any bit is eligible, the block SHALL latch the grant and the granted command (addr, write, wdata) into paddr/pwrite/pwdata, set psel=1, penable=0, and go to SETUP.
REQ-021 Arbitration SHALL be round-robin: when both are eligible, grant the requester not granted last; a single eligible requester is granted regardless of history.
REQ-022 SETUP SHALL always last exactly one cycle: set penable=1, go to ACCESS; pready is ignored in SETUP.
REQ-023 ACCESS with pready=1: rdata<=prdata on reads (unchanged on writes), done[grant]<=1, err<=0, psel=penable=0, go to IDLE.
REQ-024 ACCESS with pready=0: increment the wait counter; after TIMEOUT consecutive low cycles, abort with done[grant]<=1, err<=1, rdata<=0, psel=penable=0, go to IDLE.
REQ-025 paddr, pwrite and pwdata SHALL be stable from SETUP through the end of ACCESS; requester inputs are not sampled after the grant.
REQ-026 done and err SHALL be single-cycle pulses; done is one-hot or zero.
REQ-027 Zero-wait latency: req high in IDLE at cycle 0 gives psel at 1, penable at 2, and done at 3 if pready=1 at 2; each wait state adds one cycle.
REQ-028 The next transfer MAY begin in the IDLE cycle carrying done; the completing requester is excluded from that arbitration.

Reset
REQ-029 On rst: state=IDLE; psel, penable, pwrite, paddr, pwdata, done, err, rdata and the wait counter all 0; round-robin pointer set so requester 0 wins the first tie.
REQ-030 rst during SETUP or ACCESS SHALL abandon the transfer: no done pulse, and bus outputs are idle on the next cycle.

Structure
REQ-031 Shared package apb_pkg SHALL hold the state typedef (IDLE/SETUP/ACCESS) and the default ADDR_W/DATA_W constants.
REQ-032 Arbitration SHALL be a sub-module rr_arbiter2: inputs eligible[1:0], an update strobe and the last grant; output a one-hot grant.

Verification
REQ-033 Single read: req[0], addr 5, slave reset-initialised, pready after 1 wait -> done[0] pulse, rdata=0x5, err=0.
REQ-034 Write then read back: req[1] writes 0xDEADBEEF to addr 3, then reads addr 3 -> rdata=0xDEADBEEF; paddr/pwdata stable across SETUP/ACCESS.
REQ-035 Contention: both req high continuously -> grant order 0,1,0,1; no back-to-back grant to the same requester.
REQ-036 Timeout: pready held 0, TIMEOUT=16 -> done pulse exactly 16 ACCESS cycles after penable rises, err=1, rdata=0.
REQ-037 Reset mid-ACCESS: rst asserted while penable=1 -> next cycle psel=penable=0, done=0, and requester 0 wins the next tie.
REQ-038 Early pready: pready=1 during SETUP -> ignored; transfer completes only after ACCESS.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and constants for the two-requester APB master.
//               Holds the bus-phase state encoding and default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  localparam int APB_ADDR_W = 4;
  localparam int APB_DATA_W = 32;

  // APB bus phase: IDLE (no transfer), SETUP (psel only), ACCESS (psel+penable)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // One-hot encoding of a requester index (0 -> 2'b01, 1 -> 2'b10)
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter. A lone eligible requester always
//               wins; on a tie the requester not granted last wins.
// Ports       : pclk, rst      - clock, synchronous active-high reset
//               eligible[1:0]  - requesters competing this cycle
//               update         - strobe: last_grant is being committed
//               last_grant[1:0]- one-hot grant being committed
//               grant[1:0]     - combinational one-hot grant (or zero)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       pclk,
  input  logic       rst,
  input  logic [1:0] eligible,
  input  logic       update,
  input  logic [1:0] last_grant,
  output logic [1:0] grant
);

  // Index of the requester granted most recently. Reset to 1 so that
  // requester 0 wins the first tie.
  logic last_idx;

  always_ff @(posedge pclk) begin
    if (rst) begin
      last_idx <= 1'b1;
    end else if (update) begin
      // 2'b10 -> 1, 2'b01 -> 0, zero grant keeps history
      last_idx <= last_grant[1] | (~last_grant[0] & last_idx);
    end
  end

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_idx ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/apb_arbiter_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_arbiter_master
// Description : APB master shared by two requesters. Arbitrates round-robin,
//               runs one SETUP/ACCESS transfer per grant, returns a one-cycle
//               done pulse (with rdata/err) to the granted requester, and
//               aborts with err=1 after TIMEOUT consecutive wait cycles.
// Ports       : pclk, rst                 - clock, synchronous active-high rst
//               req/req_write[1:0]        - per-requester request/direction
//               req_addr/req_wdata        - per-requester command, packed
//               done[1:0], err, rdata     - completion pulse and result
//               psel/penable/pwrite/paddr/pwdata, pready/prdata - APB bus
// Revision    : 1.0 - initial release
// ============================================================================
module apb_arbiter_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata
);

  // Wait counter value on the last permitted low-pready ACCESS cycle
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  apb_state_t          state;
  apb_state_t          state_nxt;
  logic [1:0]          eligible;
  logic [1:0]          grant;
  logic                gidx;
  logic                start;
  logic                owner;
  logic [7:0]          wait_cnt;
  logic                timeout_hit;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // A requester that is receiving done this cycle must not be re-granted
  // off its still-high req.
  assign eligible    = req & ~done;
  assign start       = (state == ST_IDLE) && (eligible != 2'b00);
  assign gidx        = grant[1];
  assign sel_addr    = gidx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign sel_wdata   = gidx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign timeout_hit = !pready && (wait_cnt == TMO_LAST);

  rr_arbiter2 u_arb (
    .pclk       (pclk),
    .rst        (rst),
    .eligible   (eligible),
    .update     (start),
    .last_grant (grant),
    .grant      (grant)
  );

  // State register
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;   // pready ignored here
      ST_ACCESS: if (pready || timeout_hit) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Bus phase outputs follow the state directly, so reset idles the bus
  // on the very next cycle.
  always_comb begin
    psel    = (state != ST_IDLE);
    penable = (state == ST_ACCESS);
  end

  // Command latch, wait counter and completion results
  always_ff @(posedge pclk) begin
    if (rst) begin
      done     <= 2'b00;
      err      <= 1'b0;
      rdata    <= '0;
      paddr    <= '0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      owner    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      done <= 2'b00;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Requester inputs are captured only here; held through ACCESS
          if (start) begin
            paddr    <= sel_addr;
            pwrite   <= req_write[gidx];
            pwdata   <= sel_wdata;
            owner    <= gidx;
            wait_cnt <= '0;
          end
        end
        ST_ACCESS: begin
          if (pready) begin
            done <= onehot2(owner);
            if (!pwrite) rdata <= prdata;
          end else if (timeout_hit) begin
            done  <= onehot2(owner);
            err   <= 1'b1;
            rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
